// File: rtl/alu_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer_if
// Bundles the command handshake, the ALU operand/result wires, the response
// handshake and the completed-op counter of alu_cmd_sequencer.
//   master : the sequencer's view (drives cmd_ready, alu_*, rsp_*, op_count)
//   slave  : the surrounding system's view (command source, ALU, consumer)
// ---------------------------------------------------------------------------
interface alu_cmd_sequencer_if;
    // Command handshake
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    // Registered ALU inputs
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_s;
    // Combinational ALU outputs
    logic [3:0] sum_add;
    logic       carry_add;
    logic [3:0] sum_sub;
    logic       carry_sub;
    logic       greater;
    logic       equal;
    logic       less;
    logic [3:0] out_and;
    // Response handshake
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_op;
    logic [3:0] rsp_result;
    logic [2:0] rsp_flags;
    logic [7:0] op_count;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  sum_add, carry_add, sum_sub, carry_sub,
        input  greater, equal, less, out_and,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_s,
        output rsp_valid, rsp_op, rsp_result, rsp_flags, op_count
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output sum_add, carry_add, sum_sub, carry_sub,
        output greater, equal, less, out_and,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_s,
        input  rsp_valid, rsp_op, rsp_result, rsp_flags, op_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Clocked, flow-controlled front-end for a combinational 4-bit ALU. Accepts
// one command per valid/ready handshake, holds the ALU inputs for
// SETTLE_CYCLES clocks, captures the selected result into a packed response
// and holds it until the consumer takes it.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_cmd_sequencer_if.master: command, ALU and response signals
// Parameter:
//   SETTLE_CYCLES - clocks the ALU inputs are held before sampling (1..15)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_cmd_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_s_q, alu_s_d;
    logic [1:0] rsp_op_q, rsp_op_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic [2:0] rsp_flags_q, rsp_flags_d;
    logic [7:0] op_count_q, op_count_d;

    // Packs {result, flags} for the selected operation.
    function automatic logic [6:0] capture(
        input logic [1:0] sel,
        input logic [3:0] sum_add,
        input logic       carry_add,
        input logic [3:0] sum_sub,
        input logic       carry_sub,
        input logic       greater,
        input logic       equal,
        input logic       less,
        input logic [3:0] out_and
    );
        logic [6:0] r;
        case (sel)
            2'b00:   r = {sum_add, 2'b00, carry_add};
            2'b01:   r = {sum_sub, 2'b00, carry_sub};
            2'b10:   r = {4'b0000, greater, equal, less};
            default: r = {out_and, 3'b000};
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            rsp_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_s_q      <= alu_s_d;
            rsp_op_q     <= rsp_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            op_count_q   <= op_count_d;
        end
    end

    // Next-state logic; every register holds unless its state says otherwise
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_s_d      = alu_s_q;
        rsp_op_d     = rsp_op_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_d = bus.cmd_a;
                    alu_b_d = bus.cmd_b;
                    alu_s_d = bus.cmd_op;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_op_d = alu_s_q;
                    {rsp_result_d, rsp_flags_d} = capture(alu_s_q,
                        bus.sum_add, bus.carry_add, bus.sum_sub, bus.carry_sub,
                        bus.greater, bus.equal, bus.less, bus.out_and);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake flags decode from state only, no input feed-through
    always_comb begin
        bus.cmd_ready  = (state_q == IDLE);
        bus.rsp_valid  = (state_q == RESP);
        bus.alu_a      = alu_a_q;
        bus.alu_b      = alu_b_q;
        bus.alu_s      = alu_s_q;
        bus.rsp_op     = rsp_op_q;
        bus.rsp_result = rsp_result_q;
        bus.rsp_flags  = rsp_flags_q;
        bus.op_count   = op_count_q;
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Bench for alu_cmd_sequencer: one instance with SETTLE_CYCLES=1 and one
// with SETTLE_CYCLES=4, each driving a behavioural 4-bit ALU.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if if0 ();
    alu_cmd_sequencer_if if4 ();

    alu_cmd_sequencer #(.SETTLE_CYCLES(1)) u0 (.clk(clk), .rst(rst),  .bus(if0));
    alu_cmd_sequencer #(.SETTLE_CYCLES(4)) u4 (.clk(clk), .rst(rst4), .bus(if4));

    // Behavioural ALU for each instance
    assign {if0.carry_add, if0.sum_add} = {1'b0, if0.alu_a} + {1'b0, if0.alu_b};
    assign {if0.carry_sub, if0.sum_sub} = {1'b0, if0.alu_a} + {1'b0, ~if0.alu_b} + 5'd1;
    assign if0.greater = (if0.alu_a > if0.alu_b);
    assign if0.equal   = (if0.alu_a == if0.alu_b);
    assign if0.less    = (if0.alu_a < if0.alu_b);
    assign if0.out_and = if0.alu_a & if0.alu_b;

    assign {if4.carry_add, if4.sum_add} = {1'b0, if4.alu_a} + {1'b0, if4.alu_b};
    assign {if4.carry_sub, if4.sum_sub} = {1'b0, if4.alu_a} + {1'b0, ~if4.alu_b} + 5'd1;
    assign if4.greater = (if4.alu_a > if4.alu_b);
    assign if4.equal   = (if4.alu_a == if4.alu_b);
    assign if4.less    = (if4.alu_a < if4.alu_b);
    assign if4.out_and = if4.alu_a & if4.alu_b;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [2:0] flags;
    } vec_t;

    typedef struct {
        logic [1:0] op;
        logic [3:0] res;
        logic [2:0] flags;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for rsp_valid on if0, returning the number of edges waited.
    task automatic wait_rsp0(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!if0.rsp_valid && lat < 50);
        if (!if0.rsp_valid) check("rsp_valid_timeout", 32'd0, 32'd1);
    endtask

    // Compares the held response with the scoreboard head, then takes it.
    task automatic take_rsp0(input string tag);
        exp_t e;
        logic [7:0] cnt_before;
        if (sbq.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check({tag, "_rsp_op"},     32'(if0.rsp_op),     32'(e.op));
            check({tag, "_rsp_result"}, 32'(if0.rsp_result), 32'(e.res));
            check({tag, "_rsp_flags"},  32'(if0.rsp_flags),  32'(e.flags));
        end
        cnt_before = if0.op_count;
        if0.rsp_ready = 1'b1;
        tick();
        if0.rsp_ready = 1'b0;
        check({tag, "_rsp_valid_clear"}, 32'(if0.rsp_valid), 32'd0);
        check({tag, "_cmd_ready_after"}, 32'(if0.cmd_ready), 32'd1);
        check({tag, "_op_count"},        32'(if0.op_count),  32'(8'(cnt_before + 8'd1)));
    endtask

    task automatic run_vec0(input vec_t v);
        int lat;
        exp_t e;
        check({v.name, "_cmd_ready_idle"}, 32'(if0.cmd_ready), 32'd1);
        if0.cmd_op    = v.op;
        if0.cmd_a     = v.a;
        if0.cmd_b     = v.b;
        if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        e.op = v.op; e.res = v.res; e.flags = v.flags;
        sbq.push_back(e);
        check({v.name, "_alu_a"}, 32'(if0.alu_a), 32'(v.a));
        check({v.name, "_alu_b"}, 32'(if0.alu_b), 32'(v.b));
        check({v.name, "_alu_s"}, 32'(if0.alu_s), 32'(v.op));
        wait_rsp0(lat);
        check({v.name, "_latency"}, 32'(lat), 32'd1);
        take_rsp0(v.name);
    endtask

    initial begin
        int   lat;
        int   cyc;
        exp_t e;

        vecs[0] = '{"add_9_8",  2'b00, 4'h9, 4'h8, 4'h1, 3'b001};
        vecs[1] = '{"sub_3_5",  2'b01, 4'h3, 4'h5, 4'hE, 3'b000};
        vecs[2] = '{"sub_5_3",  2'b01, 4'h5, 4'h3, 4'h2, 3'b001};
        vecs[3] = '{"cmp_7_7",  2'b10, 4'h7, 4'h7, 4'h0, 3'b010};
        vecs[4] = '{"cmp_2_9",  2'b10, 4'h2, 4'h9, 4'h0, 3'b001};
        vecs[5] = '{"and_C_A",  2'b11, 4'hC, 4'hA, 4'h8, 3'b000};
        vecs[6] = '{"add_F_1",  2'b00, 4'hF, 4'h1, 4'h0, 3'b001};
        vecs[7] = '{"cmp_9_2",  2'b10, 4'h9, 4'h2, 4'h0, 3'b100};

        if0.cmd_valid = 1'b0; if0.cmd_op = 2'b00; if0.cmd_a = 4'h0; if0.cmd_b = 4'h0;
        if0.rsp_ready = 1'b0;
        if4.cmd_valid = 1'b0; if4.cmd_op = 2'b00; if4.cmd_a = 4'h0; if4.cmd_b = 4'h0;
        if4.rsp_ready = 1'b0;
        rst  = 1'b1;
        rst4 = 1'b1;
        tick();
        tick();

        // Reset values
        check("rst_rsp_valid",  32'(if0.rsp_valid),  32'd0);
        check("rst_rsp_op",     32'(if0.rsp_op),     32'd0);
        check("rst_rsp_result", 32'(if0.rsp_result), 32'd0);
        check("rst_rsp_flags",  32'(if0.rsp_flags),  32'd0);
        check("rst_alu_a",      32'(if0.alu_a),      32'd0);
        check("rst_alu_b",      32'(if0.alu_b),      32'd0);
        check("rst_alu_s",      32'(if0.alu_s),      32'd0);
        check("rst_op_count",   32'(if0.op_count),   32'd0);
        rst  = 1'b0;
        rst4 = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(if0.cmd_ready), 32'd1);

        // Table-driven operations
        for (int i = 0; i < 8; i++) run_vec0(vecs[i]);

        // Backpressure: response held while a new command waits
        if0.cmd_op = 2'b00; if0.cmd_a = 4'h1; if0.cmd_b = 4'h2; if0.cmd_valid = 1'b1;
        tick();
        e.op = 2'b00; e.res = 4'h3; e.flags = 3'b000;
        sbq.push_back(e);
        if0.cmd_op = 2'b11; if0.cmd_a = 4'hF; if0.cmd_b = 4'h6;
        wait_rsp0(lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_rsp_valid",  32'(if0.rsp_valid),  32'd1);
            check("bp_rsp_result", 32'(if0.rsp_result), 32'h3);
            check("bp_cmd_ready",  32'(if0.cmd_ready),  32'd0);
            check("bp_alu_a",      32'(if0.alu_a),      32'h1);
            check("bp_alu_b",      32'(if0.alu_b),      32'h2);
        end
        take_rsp0("bp_first");
        e.op = 2'b11; e.res = 4'h6; e.flags = 3'b000;
        sbq.push_back(e);
        tick();
        if0.cmd_valid = 1'b0;
        check("bp_next_accept_alu_a", 32'(if0.alu_a),     32'hF);
        check("bp_next_accept_alu_s", 32'(if0.alu_s),     32'h3);
        check("bp_next_cmd_ready",    32'(if0.cmd_ready), 32'd0);
        wait_rsp0(lat);
        check("bp_next_latency", 32'(lat), 32'd1);
        take_rsp0("bp_second");

        // SETTLE_CYCLES=4 latency
        if4.cmd_op = 2'b00; if4.cmd_a = 4'h9; if4.cmd_b = 4'h8; if4.cmd_valid = 1'b1;
        tick();
        if4.cmd_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!if4.rsp_valid && lat < 50);
        check("s4_latency",    32'(lat),            32'd4);
        check("s4_rsp_result", 32'(if4.rsp_result), 32'h1);
        check("s4_rsp_flags",  32'(if4.rsp_flags),  32'b001);
        if4.rsp_ready = 1'b1;
        tick();
        if4.rsp_ready = 1'b0;
        check("s4_op_count", 32'(if4.op_count), 32'd1);

        // Reset in the middle of SETTLE
        if4.cmd_op = 2'b01; if4.cmd_a = 4'h5; if4.cmd_b = 4'h3; if4.cmd_valid = 1'b1;
        tick();
        if4.cmd_valid = 1'b0;
        tick();
        check("s4_mid_settle_alu_a", 32'(if4.alu_a), 32'h5);
        #2 rst4 = 1'b1;
        #1;
        check("s4_rst_alu_a",      32'(if4.alu_a),      32'd0);
        check("s4_rst_alu_b",      32'(if4.alu_b),      32'd0);
        check("s4_rst_alu_s",      32'(if4.alu_s),      32'd0);
        check("s4_rst_rsp_valid",  32'(if4.rsp_valid),  32'd0);
        check("s4_rst_rsp_result", 32'(if4.rsp_result), 32'd0);
        check("s4_rst_rsp_flags",  32'(if4.rsp_flags),  32'd0);
        check("s4_rst_op_count",   32'(if4.op_count),   32'd0);
        tick();
        rst4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("s4_abort_no_rsp", 32'(if4.rsp_valid), 32'd0);
        end
        check("s4_abort_op_count", 32'(if4.op_count),  32'd0);
        check("s4_abort_cmd_ready", 32'(if4.cmd_ready), 32'd1);

        // Counter wrap over 256 back-to-back operations at full throughput
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wrap_start_count", 32'(if0.op_count), 32'd0);
        if0.cmd_op = 2'b11; if0.cmd_a = 4'hA; if0.cmd_b = 4'h5;
        if0.cmd_valid = 1'b1;
        if0.rsp_ready = 1'b1;
        cyc = 0;
        for (int i = 0; i < 256; i++) begin
            lat = 0;
            while (!if0.rsp_valid && lat < 10) begin
                tick();
                lat++;
                cyc++;
            end
            if (!if0.rsp_valid) begin
                check("wrap_rsp_timeout", 32'd0, 32'd1);
                break;
            end
            tick();
            cyc++;
            if (i == 254) check("wrap_count_255", 32'(if0.op_count), 32'd255);
        end
        if0.cmd_valid = 1'b0;
        if0.rsp_ready = 1'b0;
        check("wrap_count_0", 32'(if0.op_count), 32'd0);
        check("wrap_cycles",  32'(cyc),          32'd768);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
